// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter_pkg
//  Brief    : Shared widths, write-source encoding and grant-kind enum for the
//             register-file write-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int DBITS     = 32;
    localparam int REGNOBITS = 5;

    // Value driven on wr_src to tell DE where the write came from
    localparam logic WB_SRC_PIPE = 1'b0;
    localparam logic WB_SRC_LU   = 1'b1;

    // Which requester owns the write port in the current cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PIPE  = 2'd1,
        DRAIN = 2'd2,
        FORCE = 2'd3
    } grant_kind_e;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter_if
//  Brief    : Bundles the pipeline request, long-latency request, write-port
//             and hazard-query signals of the write-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface wb_port_arbiter_if
    import wb_port_arbiter_pkg::*;
#(
    parameter int DBITS     = wb_port_arbiter_pkg::DBITS,
    parameter int REGNOBITS = wb_port_arbiter_pkg::REGNOBITS,
    parameter int CNTW      = 2     // must equal $clog2(FIFO_DEPTH)+1 of the arbiter
);
    // Pipeline writeback request
    logic                 pipe_valid;
    logic                 pipe_ready;
    logic [REGNOBITS-1:0] pipe_regno;
    logic [DBITS-1:0]     pipe_data;
    // Long-latency unit result
    logic                 lu_valid;
    logic                 lu_ready;
    logic [REGNOBITS-1:0] lu_regno;
    logic [DBITS-1:0]     lu_data;
    // Registered register-file write port
    logic                 wr_reg;
    logic [REGNOBITS-1:0] wregno;
    logic [DBITS-1:0]     regval;
    logic                 wr_src;
    // Hazard query and status
    logic [REGNOBITS-1:0] query_regno;
    logic                 query_hit;
    logic [CNTW-1:0]      fifo_count;
    logic [15:0]          starve_events;

    // Arbiter side
    modport slave (
        input  pipe_valid, pipe_regno, pipe_data,
        input  lu_valid, lu_regno, lu_data,
        input  query_regno,
        output pipe_ready, lu_ready,
        output wr_reg, wregno, regval, wr_src,
        output query_hit, fifo_count, starve_events
    );

    // Requester / observer side
    modport master (
        output pipe_valid, pipe_regno, pipe_data,
        output lu_valid, lu_regno, lu_data,
        output query_regno,
        input  pipe_ready, lu_ready,
        input  wr_reg, wregno, regval, wr_src,
        input  query_hit, fifo_count, starve_events
    );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_result_fifo
//  Brief    : Small circular FIFO of long-latency results with a parallel
//             destination-register compare across all live entries.
//  Revision : 1.0  initial release
// ============================================================================
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DBITS     = wb_port_arbiter_pkg::DBITS,
    parameter int REGNOBITS = wb_port_arbiter_pkg::REGNOBITS,
    parameter int DEPTH     = 2,
    localparam int PTRW     = $clog2(DEPTH),
    localparam int CNTW     = PTRW + 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset,        // async, active-low
    input  wire logic                 push,
    input  wire logic [REGNOBITS-1:0] push_regno,
    input  wire logic [DBITS-1:0]     push_data,
    input  wire logic                 pop,
    output logic      [CNTW-1:0]      count,
    output logic      [REGNOBITS-1:0] head_regno,
    output logic      [DBITS-1:0]     head_data,
    input  wire logic [REGNOBITS-1:0] query_regno,
    output logic                      query_hit
);

    logic [PTRW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]      count_q,  count_d;
    logic [REGNOBITS-1:0] regno_q [DEPTH];
    logic [REGNOBITS-1:0] regno_d [DEPTH];
    logic [DBITS-1:0]     data_q  [DEPTH];
    logic [DBITS-1:0]     data_d  [DEPTH];
    logic [DEPTH-1:0]     match;

    // Next-state: write at tail on push, advance head on pop; pointers wrap
    // naturally because DEPTH is a power of two
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        regno_d  = regno_q;
        data_d   = data_q;
        if (push) begin
            regno_d[wr_ptr_q] = push_regno;
            data_d[wr_ptr_q]  = push_data;
            wr_ptr_d          = wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTRW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // State register; reset discards all queued results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regno_q[i] <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            regno_q  <= regno_d;
            data_q   <= data_d;
        end
    end

    // A slot is live when its distance from the head is below the occupancy
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_match
            logic [PTRW-1:0] offset;
            assign offset   = PTRW'(i) - rd_ptr_q;
            assign match[i] = ({1'b0, offset} < count_q) && (regno_q[i] == query_regno);
        end
    endgenerate

    assign query_hit  = (|match) && (query_regno != '0);
    assign count      = count_q;
    assign head_regno = regno_q[rd_ptr_q];
    assign head_data  = data_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Brief    : Shares the register-file write port between the pipeline WB
//             path (priority) and queued long-latency results, with a
//             starvation counter that forces queued results through.
//  Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DBITS        = wb_port_arbiter_pkg::DBITS,
    parameter int REGNOBITS    = wb_port_arbiter_pkg::REGNOBITS,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,     // async, active-low
    wb_port_arbiter_if.slave bus
);

    localparam int              CNTW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [CNTW-1:0] DEPTH_C    = CNTW'(FIFO_DEPTH);

    grant_kind_e          grant;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [CNTW-1:0]      fifo_count;
    logic [REGNOBITS-1:0] head_regno;
    logic [DBITS-1:0]     head_data;

    logic [3:0]           starve_cnt_q,    starve_cnt_d;
    logic [15:0]          starve_events_q, starve_events_d;
    logic                 wr_reg_q,        wr_reg_d;
    logic [REGNOBITS-1:0] wregno_q,        wregno_d;
    logic [DBITS-1:0]     regval_q,        regval_d;
    logic                 wr_src_q,        wr_src_d;

    // Readiness to accept a result comes from the registered count only, so a
    // full FIFO never accepts even when it is popping this cycle
    assign fifo_empty  = (fifo_count == '0);
    assign bus.lu_ready = (fifo_count < DEPTH_C);
    assign push        = bus.lu_valid && bus.lu_ready;
    assign pop         = (grant == FORCE) || (grant == DRAIN);

    wb_result_fifo #(
        .DBITS     (DBITS),
        .REGNOBITS (REGNOBITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_regno  (bus.lu_regno),
        .push_data   (bus.lu_data),
        .pop         (pop),
        .count       (fifo_count),
        .head_regno  (head_regno),
        .head_data   (head_data),
        .query_regno (bus.query_regno),
        .query_hit   (bus.query_hit)
    );

    // Grant decision: forced FIFO, then pipeline, then opportunistic drain
    always_comb begin
        grant = IDLE;
        if ((starve_cnt_q == STARVE_MAX) && !fifo_empty) begin
            grant = FORCE;
        end else if (bus.pipe_valid) begin
            grant = PIPE;
        end else if (!fifo_empty) begin
            grant = DRAIN;
        end
    end

    assign bus.pipe_ready = (grant != FORCE);

    // Next write-port values, starvation counter and forced-grant statistics
    always_comb begin
        wr_reg_d        = 1'b0;
        wregno_d        = wregno_q;
        regval_d        = regval_q;
        wr_src_d        = wr_src_q;
        starve_cnt_d    = starve_cnt_q;
        starve_events_d = starve_events_q;

        case (grant)
            PIPE: begin
                wr_reg_d = (bus.pipe_regno != '0);
                wregno_d = bus.pipe_regno;
                regval_d = bus.pipe_data;
                wr_src_d = WB_SRC_PIPE;
            end
            DRAIN, FORCE: begin
                wr_reg_d = (head_regno != '0);
                wregno_d = head_regno;
                regval_d = head_data;
                wr_src_d = WB_SRC_LU;
            end
            default: begin
            end
        endcase

        // A newly pushed entry does not count as waiting until next cycle
        if (fifo_empty || pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        if ((grant == FORCE) && (starve_events_q != 16'hFFFF)) begin
            starve_events_d = starve_events_q + 16'd1;
        end
    end

    // Registered write port and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_reg_q        <= 1'b0;
            wregno_q        <= '0;
            regval_q        <= '0;
            wr_src_q        <= 1'b0;
            starve_cnt_q    <= '0;
            starve_events_q <= '0;
        end else begin
            wr_reg_q        <= wr_reg_d;
            wregno_q        <= wregno_d;
            regval_q        <= regval_d;
            wr_src_q        <= wr_src_d;
            starve_cnt_q    <= starve_cnt_d;
            starve_events_q <= starve_events_d;
        end
    end

    assign bus.wr_reg        = wr_reg_q;
    assign bus.wregno        = wregno_q;
    assign bus.regval        = regval_q;
    assign bus.wr_src        = wr_src_q;
    assign bus.fifo_count    = fifo_count;
    assign bus.starve_events = starve_events_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Brief    : Directed scenarios plus randomized traffic for wb_port_arbiter,
//             checked against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DBITS        = 32;
    localparam int REGNOBITS    = 5;
    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int CNTW         = $clog2(FIFO_DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DBITS(DBITS), .REGNOBITS(REGNOBITS), .CNTW(CNTW)) bus ();

    wb_port_arbiter #(
        .DBITS        (DBITS),
        .REGNOBITS    (REGNOBITS),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [REGNOBITS-1:0] regno;
        logic [DBITS-1:0]     data;
    } ent_t;

    ent_t                 mq[$];
    int                   m_starve;
    int                   m_events;
    logic                 exp_wr_reg;
    logic [REGNOBITS-1:0] exp_wregno;
    logic [DBITS-1:0]     exp_regval;
    logic                 exp_wr_src;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_starve   = 0;
        m_events   = 0;
        exp_wr_reg = 1'b0;
        exp_wregno = '0;
        exp_regval = '0;
        exp_wr_src = 1'b0;
    endtask

    task automatic drive(input logic pv, input logic [REGNOBITS-1:0] pr, input logic [DBITS-1:0] pd,
                         input logic lv, input logic [REGNOBITS-1:0] lr, input logic [DBITS-1:0] ld,
                         input logic [REGNOBITS-1:0] qr);
        bus.pipe_valid  = pv;
        bus.pipe_regno  = pr;
        bus.pipe_data   = pd;
        bus.lu_valid    = lv;
        bus.lu_regno    = lr;
        bus.lu_data     = ld;
        bus.query_regno = qr;
    endtask

    // Called at a falling edge with inputs already driven: check every output
    // against the model, advance the model one cycle, return at next falling edge
    task automatic step();
        int   sz;
        bit   empty, frc, hit, popped;
        ent_t e;
        #1;
        sz    = mq.size();
        empty = (sz == 0);
        frc   = (m_starve == STARVE_LIMIT) && !empty;
        hit   = 1'b0;
        foreach (mq[i]) if (mq[i].regno == bus.query_regno && bus.query_regno != 0) hit = 1'b1;

        check_val("wr_reg",        64'(bus.wr_reg),        64'(exp_wr_reg));
        check_val("wregno",        64'(bus.wregno),        64'(exp_wregno));
        check_val("regval",        64'(bus.regval),        64'(exp_regval));
        check_val("wr_src",        64'(bus.wr_src),        64'(exp_wr_src));
        check_val("fifo_count",    64'(bus.fifo_count),    64'(sz));
        check_val("starve_events", 64'(bus.starve_events), 64'(m_events));
        check_val("pipe_ready",    64'(bus.pipe_ready),    64'(!frc));
        check_val("lu_ready",      64'(bus.lu_ready),      64'(sz < FIFO_DEPTH));
        check_val("query_hit",     64'(bus.query_hit),     64'(hit));

        popped = 1'b0;
        if (frc || (!bus.pipe_valid && !empty)) begin
            e          = mq.pop_front();
            exp_wr_reg = (e.regno != 0);
            exp_wregno = e.regno;
            exp_regval = e.data;
            exp_wr_src = 1'b1;
            popped     = 1'b1;
            if (frc && m_events < 65535) m_events++;
        end else if (bus.pipe_valid) begin
            exp_wr_reg = (bus.pipe_regno != 0);
            exp_wregno = bus.pipe_regno;
            exp_regval = bus.pipe_data;
            exp_wr_src = 1'b0;
        end else begin
            exp_wr_reg = 1'b0;
        end
        if (empty || popped)             m_starve = 0;
        else if (m_starve < STARVE_LIMIT) m_starve++;
        if (bus.lu_valid && sz < FIFO_DEPTH) mq.push_back('{bus.lu_regno, bus.lu_data});

        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state held while reset is low
        check_val("rst_wr_reg",     64'(bus.wr_reg),        64'd0);
        check_val("rst_fifo_count", 64'(bus.fifo_count),    64'd0);
        check_val("rst_lu_ready",   64'(bus.lu_ready),      64'd1);
        check_val("rst_pipe_ready", 64'(bus.pipe_ready),    64'd1);
        check_val("rst_events",     64'(bus.starve_events), 64'd0);
        reset = 1'b1;
        step();

        // Plain pipeline write, one-cycle latency
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0);
        step();
        check_val("pipe5_wr_reg", 64'(bus.wr_reg), 64'd1);
        check_val("pipe5_wregno", 64'(bus.wregno), 64'd5);
        check_val("pipe5_regval", 64'(bus.regval), 64'hDEADBEEF);
        check_val("pipe5_wr_src", 64'(bus.wr_src), 64'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
        step();

        // Starvation: one queued result under continuous pipeline traffic
        drive(1'b1, 5'd3, 32'h100, 1'b1, 5'd7, 32'h11, '0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h101 + i, 1'b0, '0, '0, 5'd7);
            step();
        end
        drive(1'b1, 5'd3, 32'h200, 1'b0, '0, '0, '0);
        #1;
        check_val("force_pipe_ready", 64'(bus.pipe_ready), 64'd0);
        step();
        check_val("force_wregno", 64'(bus.wregno),        64'd7);
        check_val("force_regval", 64'(bus.regval),        64'h11);
        check_val("force_wr_src", 64'(bus.wr_src),        64'd1);
        check_val("force_events", 64'(bus.starve_events), 64'd1);

        // Fill the FIFO while the pipeline keeps the port busy
        drive(1'b1, 5'd2, 32'h300, 1'b1, 5'd9, 32'hA, '0);
        step();
        drive(1'b1, 5'd2, 32'h301, 1'b1, 5'd12, 32'hB, '0);
        step();
        drive(1'b1, 5'd2, 32'h302, 1'b1, 5'd14, 32'hC, 5'd12);
        #1;
        check_val("full_lu_ready", 64'(bus.lu_ready),   64'd0);
        check_val("full_count",    64'(bus.fifo_count), 64'd2);
        check_val("full_hit",      64'(bus.query_hit),  64'd1);
        bus.query_regno = '0;
        #1;
        check_val("full_hit_x0",   64'(bus.query_hit),  64'd0);
        step();

        // Pipeline write to x0 consumes the grant but does not write
        drive(1'b1, 5'd0, 32'h400, 1'b0, '0, '0, '0);
        step();
        check_val("x0_wr_reg", 64'(bus.wr_reg), 64'd0);

        // Drain one entry, then push and pop in the same cycle
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
        step();
        drive(1'b0, '0, '0, 1'b1, 5'd20, 32'h55, '0);
        step();
        check_val("pushpop_count", 64'(bus.fifo_count), 64'd1);

        // Refill to two entries, then reset asynchronously mid-cycle
        drive(1'b1, 5'd1, 32'h500, 1'b1, 5'd21, 32'h66, '0);
        step();
        drive(1'b1, 5'd1, 32'h501, 1'b0, '0, '0, '0);
        #3;
        reset = 1'b0;
        #1;
        check_val("async_count",  64'(bus.fifo_count), 64'd0);
        check_val("async_wr_reg", 64'(bus.wr_reg),     64'd0);
        @(negedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 60),
                  5'($urandom_range(0, 7)), $urandom(),
                  ($urandom_range(0, 99) < 50),
                  5'($urandom_range(0, 7)), $urandom(),
                  5'($urandom_range(0, 7)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback path (MEM→WB) and a long-latency unit (multi-cycle mul/div, CSR side-effects). Pipeline writes have priority; long-latency results wait in a small FIFO, and a starvation counter forces them through by stalling the pipeline. The registered write-port outputs drive the DE-stage register-file write fields (`wr_reg`, `wregno`, `regval`). A query port lets DE detect hazards against results still queued.

## Interface
Parameters:
- `DBITS`, 32, data width
- `REGNOBITS`, 5, register index width
- `FIFO_DEPTH`, 2, long-latency result FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive denied cycles before a forced FIFO grant (1..15)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; state cleared while 0
- `pipe_valid`  in  1  pipeline WB write request
- `pipe_ready`  out  1  pipeline request accepted this cycle; 0 stalls WB
- `pipe_regno`  in  REGNOBITS  destination register
- `pipe_data`  in  DBITS  write value
- `lu_valid`  in  1  long-latency result available
- `lu_ready`  out  1  FIFO can accept
- `lu_regno`  in  REGNOBITS  destination register
- `lu_data`  in  DBITS  result value
- `wr_reg`  out  1  register-file write enable (registered)
- `wregno`  out  REGNOBITS  write index (registered)
- `regval`  out  DBITS  write data (registered)
- `wr_src`  out  1  0 = pipeline, 1 = FIFO (registered)
- `query_regno`  in  REGNOBITS  DE source register to check
- `query_hit`  out  1  combinational; some valid FIFO entry has `regno == query_regno`, `query_regno != 0`
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `starve_events`  out  16  saturating count of forced grants

## Operation
- FIFO push on `lu_valid && lu_ready`; `lu_ready = (fifo_count < FIFO_DEPTH)`, from registered count only (no pop-through when full).
- Grant decision per cycle, priority order:
  1. FORCE: `starve_cnt == STARVE_LIMIT` and FIFO non-empty. Grant FIFO head, `pipe_ready = 0`.
  2. PIPE: `pipe_valid`. Grant pipeline, `pipe_ready = 1`.
  3. DRAIN: FIFO non-empty. Grant FIFO head.
  4. IDLE: no grant.
- `pipe_ready = 0` only in FORCE, whether or not `pipe_valid` is asserted.
- `starve_cnt` (4 bits):
  - +1 each cycle the FIFO is non-empty and not granted, saturating at `STARVE_LIMIT`.
  - Cleared on any FIFO grant or when the FIFO is empty.
- `starve_events` +1 per FORCE cycle, saturating at 0xFFFF.
- Granted write with `regno == 0`:
  - Consumes the grant and pops / accepts as normal.
  - Registered `wr_reg = 0`.
- Entry pushed this cycle is not visible to grant or `query_hit` until next cycle.
- Simultaneous push and pop: count unchanged; pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Grant combinational from current inputs and registered state. Write-port outputs appear one cycle after grant; latency 1 from request to `wr_reg`.
- No grant: `wr_reg = 0` next cycle. `wregno`, `regval`, `wr_src` hold their last values.
- Reset (`reset == 0`, any time, asynchronous) discards FIFO contents. All values below are held until `reset` returns high:
  - `wr_reg`, `wregno`, `regval`, `wr_src` = 0
  - `fifo_count` = 0
  - `starve_cnt`, `starve_events` = 0
  - `lu_ready` = 1
  - `pipe_ready` = 1
- A FIFO result is guaranteed to write within `STARVE_LIMIT + 1` cycles of reaching the head.

## Structure
- Shared package / `VX_define.vh` holds:
  - `DBITS`, `REGNOBITS`
  - grant-source encoding (`WB_SRC_PIPE = 0`, `WB_SRC_LU = 1`)
  - grant-kind enum `{IDLE, PIPE, DRAIN, FORCE}`
- One sub-module `wb_result_fifo`:
  - push/pop, count, head outputs
  - parallel regno compare for `query_hit`
- Arbitration, starvation counter and output registers stay in the top module.

## Test plan
- Reset then idle → all outputs 0, `lu_ready = 1`, `pipe_ready = 1`.
- `pipe_valid`, regno 5, data 0xDEADBEEF, FIFO empty → next cycle `wr_reg = 1`, `wregno = 5`, `regval = 0xDEADBEEF`, `wr_src = 0`.
- Push lu (7, 0x11), `pipe_valid` held high continuously, `STARVE_LIMIT = 4` → 4 pipeline writes, then one cycle with `pipe_ready = 0`. Next cycle writes regno 7 / 0x11 with `wr_src = 1`; `starve_events = 1`.
- Fill FIFO (2 pushes, pipe busy) → `lu_ready = 0`, `fifo_count = 2`. `query_regno` matching entry 1 → `query_hit = 1`. `query_regno = 0` → `query_hit = 0`.
- Pipeline write to x0 → grant consumed, next-cycle `wr_reg = 0`. FIFO push and pop in the same cycle → `fifo_count` unchanged.
- Assert `reset = 0` with FIFO holding 2 entries → `fifo_count = 0` and `wr_reg = 0` immediately (asynchronous). After release, no stale writes.
